// File: rtl/branch_predict_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter encoding,
// per-entry bookkeeping and PC index/tag extraction.
package branch_predict_pkg;

    localparam int TAG_W    = 6;
    localparam int PC_MAX_W = 64;

    typedef enum logic [1:0] {
        CTR_SN = 2'b00,
        CTR_WN = 2'b01,
        CTR_WT = 2'b10,
        CTR_ST = 2'b11
    } ctr_e;

    // Target is kept in a separate XLEN-wide array so this struct stays width-independent.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        ctr_e             ctr;
    } entry_t;

    // Word-aligned index field pc[idx_w+1:2]; idx_w never exceeds 6 (64 entries).
    function automatic logic [5:0] pc_index(input logic [PC_MAX_W-1:0] pc, input int idx_w);
        logic [PC_MAX_W-1:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return 6'((pc >> 2) & mask);
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [PC_MAX_W-1:0] pc, input int idx_w);
        return TAG_W'(pc >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_sat_counter2.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import branch_predict_pkg::*;
(
    input  logic [1:0] state,
    input  logic       taken,
    output logic [1:0] next
);

    always_comb begin
        next = state;
        if (taken) begin
            if (state != CTR_ST) begin
                next = state + 2'd1;
            end
        end else if (state != CTR_SN) begin
            next = state - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped branch predictor with combinational fetch lookup, EX-stage
// mispredict detection/redirect and a saturating mispredict counter.
module branch_predict_ctrl
    import branch_predict_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [15:0]     mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);

    entry_t          table_q  [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [1:0]       ctr_next;
    logic             mispredict;
    logic [XLEN-1:0]  ex_pc_plus4;

    assign if_idx = IDX_W'(pc_index(PC_MAX_W'(if_pc), IDX_W));
    assign if_tag = pc_tag(PC_MAX_W'(if_pc), IDX_W);
    assign ex_idx = IDX_W'(pc_index(PC_MAX_W'(ex_pc), IDX_W));
    assign ex_tag = pc_tag(PC_MAX_W'(ex_pc), IDX_W);

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    assign if_hit      = table_q[if_idx].valid && (table_q[if_idx].tag == if_tag);
    assign pred_taken  = if_hit && table_q[if_idx].ctr[1];
    assign pred_target = pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);

    assign ex_hit      = table_q[ex_idx].valid && (table_q[ex_idx].tag == ex_tag);
    assign ex_pc_plus4 = ex_pc + XLEN'(4);

    assign mispredict  = ex_valid &&
                         ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_pred_target != ex_target)));
    assign redirect    = mispredict;
    assign redirect_pc = (mispredict && ex_taken) ? ex_target : ex_pc_plus4;

    sat_counter2 u_update_ctr (
        .state (table_q[ex_idx].ctr),
        .taken (ex_taken),
        .next  (ctr_next)
    );

    // Hits train the counter; only taken misses allocate, jumps start strongly taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i]  <= '{valid: 1'b0, tag: '0, ctr: CTR_WN};
                target_q[i] <= '0;
            end
        end else if (ex_valid) begin
            if (ex_hit) begin
                table_q[ex_idx].ctr <= ctr_e'(ctr_next);
                if (ex_taken) begin
                    target_q[ex_idx] <= ex_target;
                end
            end else if (ex_taken) begin
                table_q[ex_idx]  <= '{valid: 1'b1, tag: ex_tag, ctr: (ex_jump ? CTR_ST : CTR_WT)};
                target_q[ex_idx] <= ex_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_cnt <= '0;
        end else if (mispredict && (mispredict_cnt != 16'hFFFF)) begin
            mispredict_cnt <= mispredict_cnt + 16'd1;
        end
    end

endmodule
